// File: rtl/pid_pkg.sv
// Shared definitions for the pid block and its downstream PWM output stage:
// sign-magnitude word type, accessors, PWM FSM states and the pulse-width datapath width.
package pid_pkg;

   localparam int PWM_W = 16;

   // Sign-magnitude word: bit 31 is the sign, bits 30:0 the magnitude.
   typedef logic [31:0] sm32_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_t;

   function automatic logic sm_sign(input sm32_t v);
      return v[31];
   endfunction

   function automatic logic [30:0] sm_mag(input sm32_t v);
      return v[30:0];
   endfunction

endpackage

// File: rtl/pid_pwm_out_if.sv
// Control/status bundle between the PID controller side and the PWM output stage.
// master drives the correction, throttle and arm; slave is the pid_pwm_out block.
interface pid_pwm_out_if;
   import pid_pkg::*;

   logic             en;
   logic             pid_valid;
   sm32_t            pid_out;
   logic [PWM_W-1:0] throttle;

   logic             pwm;
   logic [PWM_W-1:0] pulse_width;
   logic             sat_hi;
   logic             sat_lo;
   logic             failsafe;

   modport master (
      output en, pid_valid, pid_out, throttle,
      input  pwm, pulse_width, sat_hi, sat_lo, failsafe
   );

   modport slave (
      input  en, pid_valid, pid_out, throttle,
      output pwm, pulse_width, sat_hi, sat_lo, failsafe
   );

endinterface

// File: rtl/pid_pwm_out_pwm_width_calc.sv
// Combinational pulse-width target: throttle +/- (PID magnitude >> CORR_SHIFT),
// clamped to [MIN_PULSE, MAX_PULSE] with saturation flags.
module pwm_width_calc
   import pid_pkg::*;
#(
   parameter int MIN_PULSE  = 1000,
   parameter int MAX_PULSE  = 2000,
   parameter int CORR_SHIFT = 5
) (
   input  sm32_t            pid_out,
   input  logic [PWM_W-1:0] throttle,
   output logic [PWM_W-1:0] target,
   output logic             sat_hi,
   output logic             sat_lo
);

   localparam logic signed [17:0] MIN_S     = 18'(MIN_PULSE);
   localparam logic signed [17:0] MAX_S     = 18'(MAX_PULSE);
   localparam logic [PWM_W-1:0]   MIN_WIDTH = PWM_W'(MIN_PULSE);
   localparam logic [PWM_W-1:0]   MAX_WIDTH = PWM_W'(MAX_PULSE);

   logic [30:0]        mag_shifted;
   logic [PWM_W-1:0]   corr;
   logic signed [17:0] sum;

   // NOTE: every output of this block gets a default before any branch so no latch is inferred.
   always_comb begin
      target = MIN_WIDTH;
      sat_hi = 1'b0;
      sat_lo = 1'b0;

      mag_shifted = sm_mag(pid_out) >> CORR_SHIFT;
      corr        = (mag_shifted > 31'h0000_FFFF) ? 16'hFFFF : mag_shifted[PWM_W-1:0];

      // Both operands are non-negative 16-bit values, so 18 signed bits cannot overflow.
      if (sm_sign(pid_out)) begin
         sum = $signed({2'b00, throttle}) - $signed({2'b00, corr});
      end else begin
         sum = $signed({2'b00, throttle}) + $signed({2'b00, corr});
      end

      if (sum > MAX_S) begin
         target = MAX_WIDTH;
         sat_hi = 1'b1;
      end else if (sum < MIN_S) begin
         target = MIN_WIDTH;
         sat_lo = 1'b1;
      end else begin
         target = sum[PWM_W-1:0];
      end
   end

endmodule

// File: rtl/pid_pwm_out.sv
// PWM output stage: registers the clamped PID-corrected width and drives a period-synchronous
// PWM with no runt pulses. Optional no-update failsafe is built when PWM_FAILSAFE_EN is defined.
module pid_pwm_out
   import pid_pkg::*;
#(
   parameter int PERIOD_CYCLES    = 20000,
   parameter int MIN_PULSE        = 1000,
   parameter int MAX_PULSE        = 2000,
   parameter int CORR_SHIFT       = 5,
   parameter int FAILSAFE_PERIODS = 50
) (
   input logic          clk,
   input logic          rst,
   pid_pwm_out_if.slave bus
);

   localparam logic [PWM_W-1:0] CNT_LAST  = PWM_W'(PERIOD_CYCLES - 1);
   localparam logic [PWM_W-1:0] MIN_WIDTH = PWM_W'(MIN_PULSE);

   if (PERIOD_CYCLES < 2 || PERIOD_CYCLES > 65535 || MIN_PULSE >= MAX_PULSE ||
       MAX_PULSE >= PERIOD_CYCLES || FAILSAFE_PERIODS < 1) begin : g_param_check
      $error("pid_pwm_out: illegal parameter combination");
   end

   pwm_state_t       state;
   logic [PWM_W-1:0] cnt;
   logic [PWM_W-1:0] active;
   logic [PWM_W-1:0] target;
   logic             pwm_q;
   logic             sat_hi_q;
   logic             sat_lo_q;

   logic [PWM_W-1:0] calc_target;
   logic             calc_sat_hi;
   logic             calc_sat_lo;
   logic             wrap;
   logic             fs_trip;

   pwm_width_calc #(
      .MIN_PULSE  (MIN_PULSE),
      .MAX_PULSE  (MAX_PULSE),
      .CORR_SHIFT (CORR_SHIFT)
   ) u_calc (
      .pid_out  (bus.pid_out),
      .throttle (bus.throttle),
      .target   (calc_target),
      .sat_hi   (calc_sat_hi),
      .sat_lo   (calc_sat_lo)
   );

   // Last cycle of a period while staying armed: the only point where active may change.
   assign wrap = (state == RUN) && bus.en && (cnt == CNT_LAST);

   // NOTE: all state here is updated with non-blocking assignments so every register
   // samples pre-edge values, e.g. active loads the old target when pid_valid hits a wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         pwm_q    <= 1'b0;
         active   <= MIN_WIDTH;
         target   <= MIN_WIDTH;
         sat_hi_q <= 1'b0;
         sat_lo_q <= 1'b0;
      end else begin
         if (bus.pid_valid) begin
            target   <= calc_target;
            sat_hi_q <= calc_sat_hi;
            sat_lo_q <= calc_sat_lo;
         end else if (fs_trip) begin
            target <= MIN_WIDTH;
         end

         case (state)
            IDLE: begin
               cnt   <= '0;
               pwm_q <= 1'b0;
               if (bus.en) begin
                  state  <= RUN;
                  active <= target;
               end else begin
                  active <= MIN_WIDTH;
               end
            end
            RUN: begin
               if (!bus.en) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  pwm_q  <= 1'b0;
                  active <= MIN_WIDTH;
               end else begin
                  pwm_q <= (cnt < active);
                  if (wrap) begin
                     cnt    <= '0;
                     active <= target;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

`ifdef PWM_FAILSAFE_EN
   localparam logic [PWM_W-1:0] FS_LAST = PWM_W'(FAILSAFE_PERIODS - 1);

   logic [PWM_W-1:0] period_cnt;
   logic             failsafe_q;

   // Trips on the wrap that completes the last allowed silent period; a fresh pid_valid wins.
   assign fs_trip = wrap && !bus.pid_valid && !failsafe_q && (period_cnt == FS_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt <= '0;
         failsafe_q <= 1'b0;
      end else if (bus.pid_valid) begin
         period_cnt <= '0;
         failsafe_q <= 1'b0;
      end else if (wrap && !failsafe_q) begin
         period_cnt <= period_cnt + 1'b1;
         if (fs_trip) begin
            failsafe_q <= 1'b1;
         end
      end
   end

   assign bus.failsafe = failsafe_q;
`else
   assign fs_trip      = 1'b0;
   assign bus.failsafe = 1'b0;
`endif

   assign bus.pwm         = pwm_q;
   assign bus.pulse_width = active;
   assign bus.sat_hi      = sat_hi_q;
   assign bus.sat_lo      = sat_lo_q;

endmodule
